// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants for the shift-register input stage
package shift_pkg;

    localparam int PRESET_N     = 8;
    localparam int PRESET_IDX_W = 3;
    localparam int SPEED_W      = 2;

    typedef logic [PRESET_IDX_W-1:0] preset_idx_t;
    typedef logic [SPEED_W-1:0]      speed_t;

    // Entry 0 sits in the low byte; it is also the post-reset pattern.
    localparam logic [PRESET_N-1:0][7:0] PRESET_TABLE = {
        8'hF0, 8'h33, 8'h81, 8'h0F, 8'h55, 8'h11, 8'h03, 8'h01
    };

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, debounce and rising-edge press pulse
// Debounce counter only exists when SHIFT_IN_DEBOUNCE_EN is defined.
module btn_debounce
    import shift_pkg::*;
#(
    parameter int NDB = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic sync_meta;
    logic sync_lvl;
    logic stable;
    logic stable_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_lvl  <= 1'b0;
            stable_d  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_lvl  <= sync_meta;
            stable_d  <= stable;
        end
    end

`ifdef SHIFT_IN_DEBOUNCE_EN
    logic [NDB-1:0] cnt;

    // The level is accepted only on a mismatch edge after the counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync_lvl == stable) begin
            cnt <= '0;
        end else if (cnt == {NDB{1'b1}}) begin
            stable <= sync_lvl;
            cnt    <= '0;
        end else begin
            cnt <= cnt + {{(NDB-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_ndb_ok;

    assign unused_ndb_ok = (NDB >= 2);
    assign stable        = sync_lvl;
`endif

    assign press = stable & ~stable_d;

endmodule

// File: rtl/shift_input_ctrl.sv
// rtl/shift_input_ctrl.sv - button conditioning, preset loader and step-tick generator
// Define SHIFT_IN_DEBOUNCE_EN to debounce the load and speed buttons.
module shift_input_ctrl
    import shift_pkg::*;
#(
    parameter int         NP  = 21,
    parameter int         NDB = 16,
    parameter logic [7:0] INI = 8'h01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_load,
    input  logic               btn_speed,
    input  logic               sw_dir,
    output logic               tick,
    output logic               load,
    output logic [7:0]         pattern,
    output logic               dir,
    output logic [SPEED_W-1:0] speed
);

    logic          load_press;
    logic          speed_press;
    logic          init_pending;
    logic          load_next;
    logic          clear_div;
    logic          tick_hit;
    logic          dir_meta;
    preset_idx_t   idx;
    preset_idx_t   idx_next;
    logic [NP-1:0] div;
    logic [NP-1:0] div_mask;

    btn_debounce #(.NDB(NDB)) u_load_btn (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_load),
        .press (load_press)
    );

    btn_debounce #(.NDB(NDB)) u_speed_btn (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_speed),
        .press (speed_press)
    );

    assign idx_next  = idx + 3'd1;
    assign load_next = init_pending | load_press;
    assign clear_div = load_next | speed_press;

    // Only the low NP-speed bits of div take part in the terminal-count compare.
    assign div_mask = {NP{1'b1}} >> speed;
    assign tick_hit = &(div | ~div_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick         <= 1'b0;
            load         <= 1'b0;
            pattern      <= INI;
            idx          <= '0;
            speed        <= '0;
            dir_meta     <= 1'b0;
            dir          <= 1'b0;
            div          <= '0;
            init_pending <= 1'b1;
        end else begin
            dir_meta     <= sw_dir;
            dir          <= dir_meta;
            init_pending <= 1'b0;
            load         <= load_next;
            tick         <= tick_hit & ~load_next;
            if (load_press) begin
                idx     <= idx_next;
                pattern <= PRESET_TABLE[idx_next];
            end
            if (speed_press) begin
                speed <= speed + SPEED_W'(1);
            end
            if (clear_div) begin
                div <= '0;
            end else begin
                div <= div + {{(NP-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_shift_input_ctrl.sv
// tb/tb_shift_input_ctrl.sv - scoreboard bench for shift_input_ctrl (NP=6, NDB=3)
module tb_shift_input_ctrl;

`ifdef SHIFT_IN_DEBOUNCE_EN
    localparam int  LAT      = 10;
    localparam bit  DEBOUNCE = 1'b1;
`else
    localparam int  LAT      = 2;
    localparam bit  DEBOUNCE = 1'b0;
`endif

    typedef struct {
        int at;
        int val;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       btn_load;
    logic       btn_speed;
    logic       sw_dir;
    logic       tick;
    logic       load;
    logic [7:0] pattern;
    logic       dir;
    logic [1:0] speed;

    int  cyc      = 0;
    int  n_chk    = 0;
    int  n_fail   = 0;
    int  tick_from = 0;
    int  idx_m    = 0;
    int  speed_m  = 0;
    bit  mon_en   = 1'b0;
    int  preset_m [8] = '{8'h01, 8'h03, 8'h11, 8'h55, 8'h0F, 8'h81, 8'h33, 8'hF0};

    ev_t load_q[$];
    ev_t tick_q[$];
    ev_t speed_q[$];
    ev_t dir_q[$];

    logic [1:0] prev_speed;
    logic       prev_dir;

    shift_input_ctrl #(.NP(6), .NDB(3), .INI(8'h01)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_load  (btn_load),
        .btn_speed (btn_speed),
        .sw_dir    (sw_dir),
        .tick      (tick),
        .load      (load),
        .pattern   (pattern),
        .dir       (dir),
        .speed     (speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected events whenever the DUT shows an output event.
    always @(negedge clk) begin
        ev_t ev;
        if (mon_en) begin
            if (load) begin
                chk("tick_during_load", int'(tick), 0);
                if (load_q.size() == 0) begin
                    chk("load_spurious", 1, 0);
                end else begin
                    ev = load_q.pop_front();
                    chk("load_edge", cyc, ev.at);
                    chk("load_pattern", int'(pattern), ev.val);
                end
            end
            if (tick && cyc > tick_from && tick_q.size() != 0) begin
                ev = tick_q.pop_front();
                chk("tick_edge", cyc, ev.at);
            end
            if (speed !== prev_speed) begin
                if (speed_q.size() == 0) begin
                    chk("speed_spurious", int'(speed), int'(prev_speed));
                end else begin
                    ev = speed_q.pop_front();
                    chk("speed_edge", cyc, ev.at);
                    chk("speed_value", int'(speed), ev.val);
                end
            end
            if (dir !== prev_dir) begin
                if (dir_q.size() == 0) begin
                    chk("dir_spurious", int'(dir), int'(prev_dir));
                end else begin
                    ev = dir_q.pop_front();
                    chk("dir_edge", cyc, ev.at);
                    chk("dir_value", int'(dir), ev.val);
                end
            end
        end
        prev_speed = speed;
        prev_dir   = dir;
    end

    task automatic wait_drain(input int limit);
        int n;
        int pending;
        n = 0;
        pending = load_q.size() + tick_q.size() + speed_q.size() + dir_q.size();
        while (pending != 0 && n < limit) begin
            @(negedge clk);
            n++;
            pending = load_q.size() + tick_q.size() + speed_q.size() + dir_q.size();
        end
        if (pending != 0) begin
            chk("drain_timeout_pending", pending, 0);
            load_q.delete();
            tick_q.delete();
            speed_q.delete();
            dir_q.delete();
        end
    endtask

    task automatic push_ticks(input int e, input int n);
        int p;
        p = 64 >> speed_m;
        tick_from = e;
        for (int k = 1; k <= n; k++) tick_q.push_back('{e + k * p, 0});
    endtask

    task automatic press(input bit is_speed, input bit with_ticks);
        int e;
        @(negedge clk);
        if (is_speed) btn_speed = 1'b1;
        else          btn_load  = 1'b1;
        e = cyc + 1 + LAT;
        if (is_speed) begin
            speed_m = (speed_m + 1) % 4;
            speed_q.push_back('{e, speed_m});
        end else begin
            idx_m = (idx_m + 1) % 8;
            load_q.push_back('{e, preset_m[idx_m]});
        end
        if (with_ticks) push_ticks(e, 2);
        repeat (20) @(negedge clk);
        btn_load  = 1'b0;
        btn_speed = 1'b0;
        repeat (20) @(negedge clk);
        wait_drain(400);
    endtask

    task automatic check_reset_values();
        chk("rst_tick", int'(tick), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_pattern", int'(pattern), 8'h01);
        chk("rst_speed", int'(speed), 0);
        chk("rst_dir", int'(dir), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst       = 1'b1;
        btn_load  = 1'b0;
        btn_speed = 1'b0;
        sw_dir    = 1'b0;

        // Reset state and post-reset load, then two ticks at period 64.
        repeat (4) @(negedge clk);
        check_reset_values();
        mon_en = 1'b1;
        rst = 1'b0;
        load_q.push_back('{cyc + 1, 8'h01});
        push_ticks(cyc + 1, 2);
        wait_drain(400);

        // Single held load press: one pulse, pattern 0x03, first tick 64 later.
        press(1'b0, 1'b1);

        // Bounce: 6 high, 1 low, 6 high.
        @(negedge clk);
        btn_load = 1'b1;
        if (!DEBOUNCE) begin
            idx_m = (idx_m + 1) % 8;
            load_q.push_back('{cyc + 1 + LAT, preset_m[idx_m]});
        end
        repeat (6) @(negedge clk);
        btn_load = 1'b0;
        @(negedge clk);
        btn_load = 1'b1;
        if (!DEBOUNCE) begin
            idx_m = (idx_m + 1) % 8;
            load_q.push_back('{cyc + 1 + LAT, preset_m[idx_m]});
        end
        repeat (6) @(negedge clk);
        btn_load = 1'b0;
        repeat (20) @(negedge clk);
        wait_drain(100);

        // Direction follows the switch two edges later.
        @(negedge clk);
        sw_dir = 1'b1;
        dir_q.push_back('{cyc + 2, 1});
        repeat (5) @(negedge clk);
        sw_dir = 1'b0;
        dir_q.push_back('{cyc + 2, 0});
        wait_drain(20);

        // Eight presses walk the whole table and wrap.
        for (int i = 0; i < 8; i++) press(1'b0, 1'b0);

        // Speed cycle: periods 32, 16, 8, 64.
        for (int i = 0; i < 4; i++) press(1'b1, 1'b1);

        // Reset mid-operation with idx=3, speed=2 and a load press in flight.
        while (idx_m != 3) press(1'b0, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        @(negedge clk);
        btn_load = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        speed_q.push_back('{cyc + 1, 0});
        repeat (2) @(negedge clk);
        btn_load = 1'b0;
        repeat (12) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        idx_m   = 0;
        speed_m = 0;
        d = cyc + 1;
        load_q.push_back('{d, 8'h01});
        push_ticks(d, 2);
        wait_drain(400);

        // A load after reset starts again from table entry 1.
        press(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
